// File: rtl/ecc_sector_sched_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ecc_sector_sched_pkg
// Brief    : Shared constants and state encoding for the ECC sector scheduler.
// Revision : 1.0 - initial release
// ============================================================================
package ecc_sector_sched_pkg;

    localparam int ECC_SECT_WORDS  = 256;
    localparam int ECC_WORD_W      = 32;
    localparam int ECC_MAX_SECTS   = 8;
    localparam int ECC_TMO_DEFAULT = 65535;

    localparam int c_st_w = 3;
    localparam logic [c_st_w-1:0] c_st_idle     = 3'd0;
    localparam logic [c_st_w-1:0] c_st_req      = 3'd1;
    localparam logic [c_st_w-1:0] c_st_load     = 3'd2;
    localparam logic [c_st_w-1:0] c_st_wait_dec = 3'd3;
    localparam logic [c_st_w-1:0] c_st_unload   = 3'd4;
    localparam logic [c_st_w-1:0] c_st_drain    = 3'd5;
    localparam logic [c_st_w-1:0] c_st_next     = 3'd6;

    // A page job must carry between 1 and max_sects sectors.
    function automatic logic sects_ok(input int sects, input int max_sects);
        return (sects != 0) && (sects <= max_sects);
    endfunction

endpackage
`default_nettype wire

// File: rtl/ecc_sector_sched_if.sv
`default_nettype none
// ============================================================================
// Module   : ecc_sector_sched_if
// Brief    : Job, stream and engine signals of the ECC sector scheduler.
// Revision : 1.0 - initial release
// ============================================================================
interface ecc_sector_sched_if
    import ecc_sector_sched_pkg::*;
#(
    parameter int MAX_SECTS = ECC_MAX_SECTS
);
    localparam int c_idx_w = $clog2(MAX_SECTS);

    logic                  page_start;
    logic [c_idx_w:0]      page_sects;
    logic                  in_valid;
    logic                  in_ready;
    logic [ECC_WORD_W-1:0] in_data;
    logic                  out_valid;
    logic [ECC_WORD_W-1:0] out_data;
    logic                  out_last;
    logic                  busy;
    logic                  page_done;
    logic                  page_err;
    logic [c_idx_w-1:0]    err_sect;
    logic                  ecc_code_req;
    logic                  ecc_code_rdy;
    logic                  wr_en;
    logic                  rd_en;
    logic [ECC_WORD_W-1:0] eng_din;
    logic [ECC_WORD_W-1:0] eng_dout;
    logic                  ecc_code_over;
    logic                  code_output_over;

    modport master (
        input  page_start, page_sects, in_valid, in_data, ecc_code_rdy,
               eng_dout, ecc_code_over, code_output_over,
        output in_ready, out_valid, out_data, out_last, busy, page_done,
               page_err, err_sect, ecc_code_req, wr_en, rd_en, eng_din
    );

    modport slave (
        output page_start, page_sects, in_valid, in_data, ecc_code_rdy,
               eng_dout, ecc_code_over, code_output_over,
        input  in_ready, out_valid, out_data, out_last, busy, page_done,
               page_err, err_sect, ecc_code_req, wr_en, rd_en, eng_din
    );

endinterface
`default_nettype wire

// File: rtl/ecc_sector_sched_tmo.sv
`default_nettype none
// ============================================================================
// Module   : ecc_tmo_cnt
// Brief    : Loadable decode-wait counter; flags the cycle it reaches the limit.
// Revision : 1.0 - initial release
// ============================================================================
module ecc_tmo_cnt #(
    parameter int TMO_CYCLES = 65535
) (
    input  logic clk,
    input  logic rst,
    input  logic i_load,
    input  logic i_en,
    output logic o_expire
);
    localparam int c_cnt_w = $clog2(TMO_CYCLES + 1);

    logic [c_cnt_w-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= '0;
        end else if (i_en) begin
            r_cnt <= r_cnt + c_cnt_w'(1);
        end
    end

    // Expire on the count that carries the counter onto TMO_CYCLES.
    assign o_expire = i_en && (r_cnt == c_cnt_w'(TMO_CYCLES - 1));

endmodule
`default_nettype wire

// File: rtl/ecc_sector_sched.sv
`default_nettype none
// ============================================================================
// Module   : ecc_sector_sched
// Brief    : Pumps each sector of a NAND page through the ECC decode engine.
// Revision : 1.0 - initial release
// ============================================================================
module ecc_sector_sched
    import ecc_sector_sched_pkg::*;
#(
    parameter int SECT_WORDS = ECC_SECT_WORDS,
    parameter int MAX_SECTS  = ECC_MAX_SECTS,
    parameter int TMO_CYCLES = ECC_TMO_DEFAULT
) (
    input  logic               clk,
    input  logic               rst,
    ecc_sector_sched_if.master bus
);
    localparam int c_idx_w  = $clog2(MAX_SECTS);
    localparam int c_wcnt_w = $clog2(SECT_WORDS) + 1;
    localparam logic [c_wcnt_w-1:0] c_last_word = c_wcnt_w'(SECT_WORDS - 1);

    logic [c_st_w-1:0]   r_state;
    logic [c_wcnt_w-1:0] r_word_cnt;
    logic [c_idx_w:0]    r_count;
    logic [c_idx_w-1:0]  r_sect_idx;
    logic [c_idx_w-1:0]  r_err_sect;
    logic                r_busy;
    logic                r_page_done;
    logic                r_page_err;
    logic                r_out_valid;
    logic                r_out_last;
    logic                r_over_seen;

    logic w_in_ready;
    logic w_accept;
    logic w_rd;
    logic w_req;
    logic w_tmo_load;
    logic w_tmo_en;
    logic w_tmo_expire;
    logic w_last_sect;

    assign w_in_ready  = (r_state == c_st_load);
    assign w_accept    = w_in_ready && bus.in_valid;
    assign w_rd        = (r_state == c_st_unload);
    assign w_req       = (r_state == c_st_req) && bus.ecc_code_rdy;
    assign w_tmo_load  = w_accept && (r_word_cnt == c_last_word);
    assign w_tmo_en    = (r_state == c_st_wait_dec);
    assign w_last_sect = (({1'b0, r_sect_idx} + (c_idx_w + 1)'(1)) == r_count);

    ecc_tmo_cnt #(
        .TMO_CYCLES (TMO_CYCLES)
    ) u_tmo (
        .clk      (clk),
        .rst      (rst),
        .i_load   (w_tmo_load),
        .i_en     (w_tmo_en),
        .o_expire (w_tmo_expire)
    );

    // Engine strobes and the write data path are combinational so each
    // accepted upstream word reaches the engine in the cycle it is accepted.
    assign bus.in_ready     = w_in_ready;
    assign bus.wr_en        = w_accept;
    assign bus.eng_din      = w_accept ? bus.in_data : '0;
    assign bus.rd_en        = w_rd;
    assign bus.ecc_code_req = w_req;
    assign bus.out_valid    = r_out_valid;
    assign bus.out_data     = r_out_valid ? bus.eng_dout : '0;
    assign bus.out_last     = r_out_last;
    assign bus.busy         = r_busy;
    assign bus.page_done    = r_page_done;
    assign bus.page_err     = r_page_err;
    assign bus.err_sect     = r_err_sect;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= c_st_idle;
            r_word_cnt  <= '0;
            r_count     <= '0;
            r_sect_idx  <= '0;
            r_err_sect  <= '0;
            r_busy      <= 1'b0;
            r_page_done <= 1'b0;
            r_page_err  <= 1'b0;
            r_out_valid <= 1'b0;
            r_out_last  <= 1'b0;
            r_over_seen <= 1'b0;
        end else begin
            r_page_done <= 1'b0;
            r_page_err  <= 1'b0;
            r_out_valid <= w_rd;
            r_out_last  <= w_rd && (r_word_cnt == c_last_word);

            case (r_state)
                c_st_idle: begin
                    if (bus.page_start) begin
                        if (sects_ok(int'(bus.page_sects), MAX_SECTS)) begin
                            r_count    <= bus.page_sects;
                            r_sect_idx <= '0;
                            r_busy     <= 1'b1;
                            r_state    <= c_st_req;
                        end else begin
                            r_page_err <= 1'b1;
                            r_err_sect <= '0;
                        end
                    end
                end
                c_st_req: begin
                    if (bus.ecc_code_rdy) begin
                        r_word_cnt <= '0;
                        r_state    <= c_st_load;
                    end
                end
                c_st_load: begin
                    if (w_accept) begin
                        r_word_cnt <= r_word_cnt + c_wcnt_w'(1);
                        if (r_word_cnt == c_last_word) begin
                            r_state <= c_st_wait_dec;
                        end
                    end
                end
                c_st_wait_dec: begin
                    if (bus.ecc_code_over) begin
                        r_word_cnt  <= '0;
                        r_over_seen <= 1'b0;
                        r_state     <= c_st_unload;
                    end else if (w_tmo_expire) begin
                        r_page_err <= 1'b1;
                        r_err_sect <= r_sect_idx;
                        r_busy     <= 1'b0;
                        r_state    <= c_st_idle;
                    end
                end
                c_st_unload: begin
                    r_word_cnt <= r_word_cnt + c_wcnt_w'(1);
                    // Hold an early output-complete so DRAIN cannot miss it.
                    if (bus.code_output_over) begin
                        r_over_seen <= 1'b1;
                    end
                    if (r_word_cnt == c_last_word) begin
                        r_state <= c_st_drain;
                    end
                end
                c_st_drain: begin
                    if (bus.code_output_over || r_over_seen) begin
                        r_state <= c_st_next;
                    end
                end
                c_st_next: begin
                    if (w_last_sect) begin
                        r_page_done <= 1'b1;
                        r_busy      <= 1'b0;
                        r_state     <= c_st_idle;
                    end else begin
                        r_sect_idx <= r_sect_idx + c_idx_w'(1);
                        r_state    <= c_st_req;
                    end
                end
                default: begin
                    r_state <= c_st_idle;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ecc_sector_sched.sv
`default_nettype none
// ============================================================================
// Module   : tb_ecc_sector_sched
// Brief    : Directed/random page jobs against an engine model and scoreboard.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ecc_sector_sched;
    import ecc_sector_sched_pkg::*;

    localparam int SW  = 256;
    localparam int MS  = 8;
    localparam int TMO = 100;
    localparam logic [31:0] KEY = 32'h5AC3_0F96;

    localparam int K_REQ = 0, K_WR = 1, K_RD = 2, K_OV = 3, K_LAST = 4, K_DONE = 5;
    localparam int K_ERR = 6, K_BAD = 7, K_LBAD = 8, K_WBAD = 9, K_BBAD = 10, K_N = 11;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    ecc_sector_sched_if #(.MAX_SECTS(MS)) ifc();

    ecc_sector_sched #(
        .SECT_WORDS (SW),
        .MAX_SECTS  (MS),
        .TMO_CYCLES (TMO)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (ifc)
    );

    // Engine model: decoded word = stored raw word XOR KEY.
    logic [31:0] eng_mem [SW];
    int eng_wp = 0, eng_rp = 0, eng_cd = 0, eng_req_cnt = 0;
    int hang_at = -1;

    always @(posedge clk) begin
        ifc.ecc_code_over    <= 1'b0;
        ifc.code_output_over <= 1'b0;
        if (rst) begin
            eng_wp       <= 0;
            eng_rp       <= 0;
            eng_cd       <= 0;
            ifc.eng_dout <= '0;
        end else begin
            if (ifc.ecc_code_req) begin
                eng_wp      <= 0;
                eng_rp      <= 0;
                eng_req_cnt <= eng_req_cnt + 1;
            end
            if (ifc.wr_en) begin
                eng_mem[eng_wp] <= ifc.eng_din;
                eng_wp <= eng_wp + 1;
                if (eng_wp == SW - 1) eng_cd <= 10;
            end else if (eng_cd > 0) begin
                eng_cd <= eng_cd - 1;
                if (eng_cd == 1 && eng_req_cnt != hang_at) ifc.ecc_code_over <= 1'b1;
            end
            if (ifc.rd_en) begin
                ifc.eng_dout <= eng_mem[eng_rp] ^ KEY;
                eng_rp <= eng_rp + 1;
                if (eng_rp == SW - 1) ifc.code_output_over <= 1'b1;
            end
        end
    end

    // Monitor + scoreboard: every accepted word must come back XOR KEY, in order.
    int cnt [K_N];
    int n_neg = 0, last_wr_at = 0, err_at = 0, ow_idx = 0;
    logic [31:0] exp_q [$];

    initial for (int i = 0; i < K_N; i++) cnt[i] = 0;

    always @(negedge clk) begin
        n_neg <= n_neg + 1;
        if (rst) begin
            exp_q.delete();
            ow_idx <= 0;
        end else begin
            if (ifc.in_valid && ifc.in_ready) exp_q.push_back(ifc.in_data ^ KEY);
            if ((ifc.wr_en !== (ifc.in_valid && ifc.in_ready)) ||
                (ifc.wr_en && ifc.eng_din !== ifc.in_data)) cnt[K_WBAD] <= cnt[K_WBAD] + 1;
            if (ifc.wr_en) begin
                cnt[K_WR] <= cnt[K_WR] + 1;
                last_wr_at <= n_neg;
            end
            if (ifc.rd_en) cnt[K_RD] <= cnt[K_RD] + 1;
            if (ifc.ecc_code_req) cnt[K_REQ] <= cnt[K_REQ] + 1;
            if (ifc.out_valid) begin
                cnt[K_OV] <= cnt[K_OV] + 1;
                if (exp_q.size() == 0 || ifc.out_data !== exp_q.pop_front())
                    cnt[K_BAD] <= cnt[K_BAD] + 1;
                if (ifc.out_last !== (ow_idx % SW == SW - 1)) cnt[K_LBAD] <= cnt[K_LBAD] + 1;
                ow_idx <= ow_idx + 1;
            end else if (ifc.out_last) begin
                cnt[K_LBAD] <= cnt[K_LBAD] + 1;
            end
            if (ifc.out_last) cnt[K_LAST] <= cnt[K_LAST] + 1;
            if (ifc.page_done) begin
                cnt[K_DONE] <= cnt[K_DONE] + 1;
                if (ifc.busy) cnt[K_BBAD] <= cnt[K_BBAD] + 1;
            end
            if (ifc.page_err) begin
                cnt[K_ERR] <= cnt[K_ERR] + 1;
                err_at <= n_neg;
            end
        end
    end

    int checks = 0;
    int failures = 0;
    int base [K_N];

    task automatic chk(input string tag, input longint obs, input longint exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic int d(input int k);
        return cnt[k] - base[k];
    endfunction

    task automatic start_job(input int n);
        @(posedge clk); #1;
        ifc.page_sects = 4'(n);
        ifc.page_start = 1'b1;
        @(posedge clk); #1;
        ifc.page_start = 1'b0;
    endtask

    task automatic feed(input int nwords, input bit stall);
        int fed = 0;
        for (int c = 0; c < 20000 && fed < nwords; c++) begin
            @(posedge clk); #1;
            ifc.in_valid = !(stall && (c % 3 == 2));
            ifc.in_data  = $urandom;
            if (ifc.in_valid && ifc.in_ready) fed++;
        end
        @(posedge clk); #1;
        ifc.in_valid = 1'b0;
    endtask

    task automatic wait_end(input int budget, input string tag);
        int c;
        for (c = 0; c < budget; c++) begin
            @(negedge clk);
            if (ifc.page_done || ifc.page_err) break;
        end
        chk({tag, "_ends_in_budget"}, longint'(c < budget), 1);
    endtask

    initial begin
        ifc.page_start   = 1'b0;
        ifc.page_sects   = '0;
        ifc.in_valid     = 1'b0;
        ifc.in_data      = '0;
        ifc.ecc_code_rdy = 1'b1;
        repeat (5) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("reset_outputs",
            {ifc.busy, ifc.in_ready, ifc.out_valid, ifc.out_last, ifc.page_done,
             ifc.page_err, ifc.ecc_code_req, ifc.wr_en, ifc.rd_en, ifc.err_sect}, 0);

        // Single sector, continuous input.
        base = cnt;
        start_job(1);
        chk("t1_req_latency", ifc.ecc_code_req, 1);
        fork
            feed(SW, 1'b0);
            wait_end(3000, "t1");
        join
        repeat (3) @(negedge clk);
        chk("t1_wr",    d(K_WR), SW);
        chk("t1_rd",    d(K_RD), SW);
        chk("t1_ov",    d(K_OV), SW);
        chk("t1_last",  d(K_LAST), 1);
        chk("t1_lbad",  d(K_LBAD), 0);
        chk("t1_data",  d(K_BAD), 0);
        chk("t1_done",  d(K_DONE), 1);
        chk("t1_busy_at_done", d(K_BBAD), 0);
        chk("t1_busy",  ifc.busy, 0);
        chk("t1_q",     exp_q.size(), 0);

        // Four sectors, stalling input, stray page_start mid-job.
        base = cnt;
        start_job(4);
        fork
            feed(4 * SW, 1'b1);
            wait_end(8000, "t2");
            begin
                repeat (400) @(posedge clk);
                #1 ifc.page_sects = 4'd1;
                ifc.page_start = 1'b1;
                @(posedge clk); #1;
                ifc.page_start = 1'b0;
            end
        join
        repeat (3) @(negedge clk);
        chk("t2_req",   d(K_REQ), 4);
        chk("t2_ov",    d(K_OV), 4 * SW);
        chk("t2_data",  d(K_BAD), 0);
        chk("t2_last",  d(K_LAST), 4);
        chk("t2_lbad",  d(K_LBAD), 0);
        chk("t2_done",  d(K_DONE), 1);
        chk("t2_err",   d(K_ERR), 0);
        chk("t2_wr_ok", d(K_WBAD), 0);

        // Engine not ready for 50 cycles.
        base = cnt;
        ifc.ecc_code_rdy = 1'b0;
        start_job(1);
        repeat (50) @(negedge clk);
        chk("t3_no_req_while_busy_engine", d(K_REQ), 0);
        ifc.ecc_code_rdy = 1'b1;
        fork
            feed(SW, 1'b0);
            wait_end(3000, "t3");
        join
        repeat (3) @(negedge clk);
        chk("t3_req",  d(K_REQ), 1);
        chk("t3_done", d(K_DONE), 1);
        chk("t3_ov",   d(K_OV), SW);

        // Decode timeout in sector index 2 of 3.
        base = cnt;
        hang_at = eng_req_cnt + 3;
        start_job(3);
        fork
            feed(3 * SW, 1'b0);
            wait_end(6000, "t4");
        join
        chk("t4_busy",     ifc.busy, 0);
        chk("t4_err_sect", ifc.err_sect, 2);
        repeat (3) @(negedge clk);
        chk("t4_err",      d(K_ERR), 1);
        chk("t4_done",     d(K_DONE), 0);
        chk("t4_delay",    err_at - last_wr_at, TMO + 1);
        chk("t4_idle",     ifc.in_ready, 0);
        hang_at = -1;

        // Invalid sector counts.
        for (int k = 0; k < 2; k++) begin
            base = cnt;
            start_job(k == 0 ? 0 : MS + 1);
            chk("t5_err_next_cycle", ifc.page_err, 1);
            chk("t5_err_sect", ifc.err_sect, 0);
            repeat (5) @(negedge clk);
            chk("t5_err_cnt", d(K_ERR), 1);
            chk("t5_no_req",  d(K_REQ), 0);
            chk("t5_busy",    ifc.busy, 0);
        end

        // Reset in the middle of UNLOAD, then a clean job.
        base = cnt;
        start_job(1);
        fork
            feed(SW, 1'b0);
            begin
                for (int c = 0; c < 3000; c++) begin
                    @(negedge clk);
                    if (ifc.rd_en) break;
                end
                repeat (20) @(negedge clk);
            end
        join
        chk("t6_in_unload", ifc.rd_en, 1);
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1;
        chk("t6_reset_outputs",
            {ifc.busy, ifc.in_ready, ifc.out_valid, ifc.out_last, ifc.page_done,
             ifc.page_err, ifc.ecc_code_req, ifc.wr_en, ifc.rd_en, ifc.err_sect,
             ifc.out_data, ifc.eng_din}, 0);
        rst = 1'b0;
        repeat (5) @(negedge clk);
        chk("t6_no_done_err", d(K_DONE) + d(K_ERR), 0);
        base = cnt;
        start_job(1);
        fork
            feed(SW, 1'b0);
            wait_end(3000, "t6");
        join
        repeat (3) @(negedge clk);
        chk("t6_wr",   d(K_WR), SW);
        chk("t6_ov",   d(K_OV), SW);
        chk("t6_data", d(K_BAD), 0);
        chk("t6_done", d(K_DONE), 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/ecc_sector_sched.md
Name: ecc_sector_sched

Overview:
- Sequences the ECC decode engine (the ecc_code_req/wr_en/rd_en engine wrapper) across a multi-sector NAND page.
- Accepts a page job from the NAND read path and pumps sector data into the engine. It then waits for the decode, drains the decoded words to the downstream buffer, and repeats until all sectors are done.
- Sits between the flash read datapath and the page buffer. It is the engine's only master.

Parameters:
SECT_WORDS, 256, 32-bit words per sector (8192 data bits)
MAX_SECTS, 8, maximum sectors per page
TMO_CYCLES, 65535, max cycles to wait for ecc_code_over before abort

Ports:
clk  in  1  system clock
rst  in  1  synchronous reset, active-high
page_start  in  1  1-cycle job pulse; ignored unless idle
page_sects  in  $clog2(MAX_SECTS)+1  sector count, sampled on page_start; 0 or >MAX_SECTS -> page_err
in_valid  in  1  upstream word valid
in_ready  out  1  scheduler accepts word
in_data  in  32  upstream raw word
out_valid  out  1  decoded word valid (no backpressure)
out_data  out  32  decoded word
out_last  out  1  with final word of each sector
busy  out  1  job in progress
page_done  out  1  1-cycle pulse, job finished OK
page_err  out  1  1-cycle pulse, job aborted
err_sect  out  $clog2(MAX_SECTS)  sector index at abort
ecc_code_req  out  1  engine start pulse
ecc_code_rdy  in  1  engine idle/ready
wr_en  out  1  engine write strobe
rd_en  out  1  engine read strobe
eng_din  out  32  word to engine data_in
eng_dout  in  32  engine data_out, valid 1 cycle after rd_en
ecc_code_over  in  1  engine decode-complete pulse
code_output_over  in  1  engine output-complete pulse

Behaviour:
- Reset: all outputs 0, state IDLE, counters 0. Reset mid-job discards the job with no done/err pulse.
- States: IDLE, REQ, LOAD, WAIT_DEC, UNLOAD, DRAIN, NEXT.
- IDLE:
  - page_start with valid count: latch count, sect_idx=0, busy=1, go to REQ.
  - Invalid count: page_err pulse next cycle, err_sect=0, stay IDLE.
- REQ: when ecc_code_rdy=1, assert ecc_code_req for exactly 1 cycle, word_cnt=0, go to LOAD.
- LOAD:
  - in_ready=1. On in_valid&in_ready: wr_en=1 and eng_din=in_data in the same cycle (combinational pass-through), word_cnt++.
  - After word SECT_WORDS-1 is written, go to WAIT_DEC and reset tmo_cnt.
  - in_ready=0 in all other states.
- WAIT_DEC:
  - tmo_cnt increments each cycle. ecc_code_over -> UNLOAD, word_cnt=0.
  - tmo_cnt reaching TMO_CYCLES -> page_err pulse, err_sect=sect_idx, go to IDLE.
  - ecc_code_over seen in any state other than WAIT_DEC is ignored.
- UNLOAD:
  - rd_en=1 for SECT_WORDS consecutive cycles.
  - out_valid is rd_en delayed 1 cycle; out_data=eng_dout.
  - out_last accompanies the word read by the final rd_en.
- DRAIN: wait for code_output_over. Its arrival may coincide with the final out_valid and must still be captured. Then go to NEXT.
- NEXT:
  - sect_idx+1==count: page_done pulse, busy=0, go to IDLE.
  - Otherwise sect_idx++, go to REQ.
- Latency: ecc_code_req appears 1 cycle after page_start when ecc_code_rdy is already high. page_done is ≥1 cycle after code_output_over.
- Simultaneous page_start while busy: ignored, no error.
- Counter widths: word_cnt $clog2(SECT_WORDS)+1; tmo_cnt $clog2(TMO_CYCLES+1). No wrap occurs within legal operation.
- DRAIN has no timeout (code_output_over is guaranteed after the final rd_en).

Decomposition:
- Shared package: state encoding, ECC_SECT_WORDS=256, ECC_WORD_W=32, timeout default.
- One natural sub-module: ecc_tmo_cnt (loadable timeout counter with expire flag). Everything else stays in a single FSM module.

Test Plan:
- Single sector: page_sects=1, 256 words with continuous in_valid, engine model pulses over 10 cycles after the last wr_en -> exactly 256 wr_en, 256 rd_en, 256 out_valid, out_last on word 255, one page_done, busy drops the same cycle.
- 4-sector page with in_valid stalling every 3rd cycle -> 4 ecc_code_req pulses, 1024 output words in order, 4 out_last, one page_done, no wr_en while in_valid=0.
- ecc_code_rdy held low for 50 cycles after page_start -> ecc_code_req is delayed until rdy=1, with no extra req pulses.
- Engine never pulses over, TMO_CYCLES=100 in sector 2 of 3 -> page_err exactly 100 cycles after entering WAIT_DEC, err_sect=2, back to IDLE, busy=0.
- page_sects=0, and separately page_sects=MAX_SECTS+1 -> page_err pulse, no ecc_code_req. Second page_start pulse mid-job -> ignored.
- rst asserted during UNLOAD -> next cycle all outputs 0 and state IDLE. A fresh 1-sector job then completes normally.
